// File: rtl/s5b_pkg.sv
// Shared definitions for the Sunsoft 5B PSG: register map, envelope shape bits,
// logarithmic volume table and channel/envelope state types.
package s5b_pkg;

  localparam logic [3:0] R_TONE_A_LO = 4'd0;
  localparam logic [3:0] R_TONE_A_HI = 4'd1;
  localparam logic [3:0] R_TONE_B_LO = 4'd2;
  localparam logic [3:0] R_TONE_B_HI = 4'd3;
  localparam logic [3:0] R_TONE_C_LO = 4'd4;
  localparam logic [3:0] R_TONE_C_HI = 4'd5;
  localparam logic [3:0] R_NOISE     = 4'd6;
  localparam logic [3:0] R_MIXER     = 4'd7;
  localparam logic [3:0] R_VOL_A     = 4'd8;
  localparam logic [3:0] R_VOL_B     = 4'd9;
  localparam logic [3:0] R_VOL_C     = 4'd10;
  localparam logic [3:0] R_ENV_LO    = 4'd11;
  localparam logic [3:0] R_ENV_HI    = 4'd12;
  localparam logic [3:0] R_ENV_SHAPE = 4'd13;

  localparam int SHAPE_HOLD = 0;
  localparam int SHAPE_ALT  = 1;
  localparam int SHAPE_ATT  = 2;
  localparam int SHAPE_CONT = 3;

  // 1.5 dB per step below full scale; entry 0 is true silence.
  localparam logic [9:0] VOL_LUT [32] = '{
    10'd0,   10'd6,   10'd7,   10'd8,   10'd10,  10'd11,  10'd14,  10'd16,
    10'd19,  10'd23,  10'd27,  10'd32,  10'd38,  10'd46,  10'd54,  10'd65,
    10'd77,  10'd91,  10'd108, 10'd129, 10'd153, 10'd182, 10'd216, 10'd257,
    10'd305, 10'd363, 10'd431, 10'd513, 10'd609, 10'd724, 10'd861, 10'd1023
  };

  typedef struct packed {
    logic [11:0] cnt;
    logic        sq;
  } tone_t;

  typedef enum logic [1:0] {ATTACK, DECAY, HOLD_LVL} env_state_t;

endpackage

// File: rtl/s5b_env.sv
// Envelope generator: period counter plus a 5-bit level stepped by the shape FSM.
module s5b_env
  import s5b_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        env_en,
  input  logic [15:0] period,
  input  logic [3:0]  shape,
  input  logic        restart,
  input  logic        restart_att,
  output logic [4:0]  level
);

  env_state_t  state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [4:0]  level_nxt;
  logic [16:0] per_eff;
  logic        at_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ATTACK;
      level <= 5'd0;
      cnt   <= 16'd0;
    end else if (!enable) begin
      state <= ATTACK;
      level <= 5'd0;
      cnt   <= 16'd0;
    end else begin
      state <= state_nxt;
      level <= level_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A shape write restarts the envelope and takes priority over any step in the same cycle.
  always_comb begin
    state_nxt = state;
    level_nxt = level;
    cnt_nxt   = cnt;
    per_eff   = (period == 16'd0) ? 17'd1 : {1'b0, period};
    at_end    = (state == ATTACK && level == 5'd31) || (state == DECAY && level == 5'd0);
    if (restart) begin
      cnt_nxt   = 16'd0;
      state_nxt = restart_att ? ATTACK : DECAY;
      level_nxt = restart_att ? 5'd0 : 5'd31;
    end else if (env_en && state != HOLD_LVL) begin
      if ({1'b0, cnt} + 17'd1 >= per_eff) begin
        cnt_nxt = 16'd0;
        if (!at_end) begin
          level_nxt = (state == ATTACK) ? level + 5'd1 : level - 5'd1;
        end else if (!shape[SHAPE_CONT]) begin
          level_nxt = 5'd0;
          state_nxt = HOLD_LVL;
        end else if (shape[SHAPE_HOLD]) begin
          state_nxt = HOLD_LVL;
          if (shape[SHAPE_ALT]) level_nxt = ~level;
        end else if (shape[SHAPE_ALT]) begin
          state_nxt = (state == ATTACK) ? DECAY : ATTACK;
          level_nxt = (state == ATTACK) ? level - 5'd1 : level + 5'd1;
        end else begin
          level_nxt = (state == ATTACK) ? 5'd0 : 5'd31;
        end
      end else begin
        cnt_nxt = cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/s5b_psg.sv
// Sunsoft 5B / YM2149-subset sound generator: register file, timebase, three tone
// channels, noise LFSR, envelope and a summing mixer producing a 12-bit sample.
module s5b_psg
  import s5b_pkg::*;
#(
  parameter int TICK_DIV = 28
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        wr_addr,
  input  logic        wr_data,
  input  logic [7:0]  din,
  output logic [7:0]  rd_data,
  output logic [11:0] audio_out
);

  logic [7:0]  regs [16];
  logic [3:0]  reg_sel;
  logic [7:0]  presc;
  logic [3:0]  tick_cnt;
  logic        tick, tone_en, noise_en;
  logic [4:0]  noise_cnt;
  logic [5:0]  noise_per;
  logic [16:0] lfsr;
  logic [4:0]  env_level;
  logic [9:0]  sample [3];

  assign rd_data   = regs[reg_sel];
  assign tick      = (presc == 8'(TICK_DIV - 1));
  assign tone_en   = tick && (tick_cnt[2:0] == 3'd7);
  assign noise_en  = tick && (tick_cnt == 4'd15);
  assign noise_per = (regs[R_NOISE][4:0] == 5'd0) ? 6'd1 : {1'b0, regs[R_NOISE][4:0]};

  // Data goes to the previously selected register before reg_sel moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) regs[i] <= 8'd0;
      reg_sel <= 4'd0;
    end else if (!enable) begin
      for (int i = 0; i < 16; i++) regs[i] <= 8'd0;
      reg_sel <= 4'd0;
    end else begin
      if (wr_data) regs[reg_sel] <= din;
      if (wr_addr) reg_sel <= din[3:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc    <= 8'd0;
      tick_cnt <= 4'd0;
    end else if (!enable) begin
      presc    <= 8'd0;
      tick_cnt <= 4'd0;
    end else if (tick) begin
      presc    <= 8'd0;
      tick_cnt <= tick_cnt + 4'd1;
    end else begin
      presc    <= presc + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      noise_cnt <= 5'd0;
      lfsr      <= 17'h1;
    end else if (!enable) begin
      noise_cnt <= 5'd0;
      lfsr      <= 17'h1;
    end else if (noise_en) begin
      if ({1'b0, noise_cnt} + 6'd1 >= noise_per) begin
        noise_cnt <= 5'd0;
        lfsr      <= {lfsr[0] ^ lfsr[3], lfsr[16:1]};
      end else begin
        noise_cnt <= noise_cnt + 5'd1;
      end
    end
  end

  s5b_env u_env (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .env_en      (tone_en),
    .period      ({regs[R_ENV_HI], regs[R_ENV_LO]}),
    .shape       (regs[R_ENV_SHAPE][3:0]),
    .restart     (wr_data && reg_sel == R_ENV_SHAPE),
    .restart_att (din[SHAPE_ATT]),
    .level       (env_level)
  );

  for (genvar ch = 0; ch < 3; ch++) begin : g_ch
    tone_t       tone;
    logic [11:0] period;
    logic [12:0] per_eff;
    logic [3:0]  vol;
    logic [4:0]  idx;
    logic        gate;

    assign period  = {regs[2*ch+1][3:0], regs[2*ch]};
    assign per_eff = (period == 12'd0) ? 13'd1 : {1'b0, period};

    // A period shrunk below the running count wraps on the very next tone_en.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tone <= '0;
      end else if (!enable) begin
        tone <= '0;
      end else if (tone_en) begin
        if ({1'b0, tone.cnt} + 13'd1 >= per_eff) begin
          tone.cnt <= 12'd0;
          tone.sq  <= ~tone.sq;
        end else begin
          tone.cnt <= tone.cnt + 12'd1;
        end
      end
    end

    assign gate = (tone.sq | regs[R_MIXER][ch]) & (lfsr[0] | regs[R_MIXER][ch+3]);
    assign vol  = regs[8+ch][3:0];
    assign idx  = regs[8+ch][4] ? env_level : ((vol == 4'd0) ? 5'd0 : {vol, 1'b1});
    assign sample[ch] = gate ? VOL_LUT[idx] : 10'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      audio_out <= 12'd0;
    end else if (!enable) begin
      audio_out <= 12'd0;
    end else begin
      audio_out <= {2'b00, sample[0]} + {2'b00, sample[1]} + {2'b00, sample[2]};
    end
  end

endmodule
